serial_comparator: RTL and testbench
====================================

# serial_comparator

Parametrised sequential magnitude comparator. Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, under a start/busy/done handshake, in unsigned or two's-complement mode. Reports one-hot greater/equal/less flags and the number of digit cycles used. Successor to the three-bit combinational comparator; shared by datapath labs that need wide compares without a wide combinational chain.

## Interface

- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIGIT, 1: bits compared per cycle; must divide WIDTH. N = WIDTH/DIGIT digits.
- EARLY_EXIT, 1: 1 = finish on the first differing digit; 0 = always examine all N digits.

- clk  input  1  clock, rising edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy = 0.
- A  input  WIDTH  operand A; sampled with accepted start.
- B  input  WIDTH  operand B; sampled with accepted start.
- is_signed  input  1  1 = two's-complement compare; sampled with accepted start.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse: result valid and updated.
- f1  output  1  A > B.
- f2  output  1  A == B.
- f3  output  1  A < B.
- cycles  output  $clog2(N)+1  digit cycles used by the last comparison (1..N).

## Operation

- States: IDLE, CMP. done is a registered pulse, not a state.
- IDLE: busy = 0. On clk edge with start = 1: latch A, B, is_signed into internal registers; digit index ← N-1; go CMP; busy ← 1. start ignored while busy = 1.
- Signed mode: MSB of both latched operands is inverted at latch time; remaining compare is unsigned. Unsigned mode: no inversion.
- CMP, each edge: compare digit [index*DIGIT +: DIGIT] of latched A vs B; increment cycle counter.
  - Digit differs and first difference not yet recorded: record gt/lt.
  - EARLY_EXIT = 1 and digit differs, or index = 0: finish.
  - Otherwise index ← index-1, stay CMP.
- Finish (same edge): f1/f2/f3 ← one-hot result (f2 if no difference recorded); cycles ← digits examined; done ← 1; busy ← 0; state ← IDLE.
- With EARLY_EXIT = 0 the first differing digit (most significant) decides; later digits never override.
- f1/f2/f3/cycles hold their value from the last finish until the next finish; an accepted start does not clear them.
- Exactly one of f1/f2/f3 high after any completed comparison; all low only before the first completion after reset.

## Timing

- Reset (asynchronous, any time, including mid-comparison): state IDLE, busy 0, done 0, f1 f2 f3 000, cycles 0, internal registers 0. Aborted comparison produces no done.
- start accepted at edge 0 → busy = 1 after edge 0. Digit j (j = 1..k) compared at edge j. After edge k: done = 1, busy = 0, results valid. After edge k+1: done = 0.
- k = N with EARLY_EXIT = 0 or equal operands; otherwise k = position (from top, 1-based) of first differing digit.
- start high at edge k (busy still 1) is ignored; start at edge k+1 is accepted. Back-to-back throughput: one comparison per k+1 cycles.
- A, B, is_signed may change freely after the accepting edge.

## Test plan

- WIDTH=8, DIGIT=1, unsigned, A=0x80, B=0x7F → done after edge 1; f1 f2 f3 = 100; cycles = 1.
- Same operands, is_signed=1 → f1 f2 f3 = 001 (-128 < 127); cycles = 1.
- A=B=0x5A → done after edge 8; 010; cycles = 8; busy high exactly 8 cycles.
- DIGIT=2, A=0x03, B=0x02 → differ in lowest digit; done after edge 4; 100; cycles = 4. EARLY_EXIT=0, A=0xF0, B=0x0F → 100, cycles = 8.
- start held high continuously, A=0x10, B=0x20 → second start accepted one cycle after done; no start taken while busy; each done pulse one cycle wide with 001.
- rst asserted mid-comparison (after edge 3 of an 8-cycle compare) → immediately busy 0, flags 000, cycles 0; no done; next start completes normally.

Source files
------------

// File: rtl/serial_comparator.sv
// serial_comparator: MSB-first digit-serial magnitude compare with
// start/busy/done handshake, unsigned or two's-complement operands.
module serial_comparator #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              A,
    input  logic [WIDTH-1:0]              B,
    input  logic                          is_signed,
    output logic                          busy,
    output logic                          done,
    output logic                          f1,
    output logic                          f2,
    output logic                          f3,
    output logic [$clog2(WIDTH/DIGIT):0]  cycles
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt;
    logic             rec;
    logic             gt_r;
    logic             lt_r;

    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic             diff;
    logic             nrec;
    logic             ngt;
    logic             nlt;
    logic             last;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] msb;

    // operands shift left each cycle so the live digit is always on top
    always_comb begin
        msb    = {is_signed, {(WIDTH-1){1'b0}}};
        da     = a_r[WIDTH-1 -: DIGIT];
        db     = b_r[WIDTH-1 -: DIGIT];
        diff   = (da != db);
        nrec   = rec | diff;
        ngt    = rec ? gt_r : (diff & (da > db));
        nlt    = rec ? lt_r : (diff & (da < db));
        cnt_nx = cnt + CW'(1);
        last   = ((EARLY_EXIT != 0) && diff) || (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            cnt    <= '0;
            rec    <= 1'b0;
            gt_r   <= 1'b0;
            lt_r   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            f1     <= 1'b0;
            f2     <= 1'b0;
            f3     <= 1'b0;
            cycles <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= A ^ msb;
                        b_r   <= B ^ msb;
                        cnt   <= '0;
                        rec   <= 1'b0;
                        gt_r  <= 1'b0;
                        lt_r  <= 1'b0;
                        busy  <= 1'b1;
                        state <= CMP;
                    end
                end
                CMP: begin
                    a_r  <= a_r << DIGIT;
                    b_r  <= b_r << DIGIT;
                    cnt  <= cnt_nx;
                    rec  <= nrec;
                    gt_r <= ngt;
                    lt_r <= nlt;
                    if (last) begin
                        f1     <= ngt;
                        f2     <= ~nrec;
                        f3     <= nlt;
                        cycles <= cnt_nx;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator: three configurations,
// directed vectors, handshake timing and async reset abort.
module tb_serial_comparator;

    typedef struct {
        int         id;
        logic [2:0] f;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       st  [3];
    logic [7:0] av  [3];
    logic [7:0] bv  [3];
    logic       sg  [3];
    logic       busy[3];
    logic       done[3];
    logic       f1s [3];
    logic       f2s [3];
    logic       f3s [3];
    logic [3:0] cyc [3];
    logic [2:0] cyc1;

    exp_t q[$];
    exp_t m;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // 0: DIGIT=1 early exit, 1: DIGIT=2 early exit, 2: DIGIT=1 full scan
    serial_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .A(av[0]), .B(bv[0]),
        .is_signed(sg[0]), .busy(busy[0]), .done(done[0]),
        .f1(f1s[0]), .f2(f2s[0]), .f3(f3s[0]), .cycles(cyc[0])
    );

    serial_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .A(av[1]), .B(bv[1]),
        .is_signed(sg[1]), .busy(busy[1]), .done(done[1]),
        .f1(f1s[1]), .f2(f2s[1]), .f3(f3s[1]), .cycles(cyc1)
    );

    assign cyc[1] = {1'b0, cyc1};

    serial_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .A(av[2]), .B(bv[2]),
        .is_signed(sg[2]), .busy(busy[2]), .done(done[2]),
        .f1(f1s[2]), .f2(f2s[2]), .f3(f3s[2]), .cycles(cyc[2])
    );

    task automatic chk(input string n, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, got, want);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done dut=%0d got=1 want=0", i);
                end else begin
                    m = q.pop_front();
                    chk("mon_dut", i, m.id);
                    chk("mon_flags", int'({f1s[i], f2s[i], f3s[i]}), int'(m.f));
                    chk("mon_cycles", int'(cyc[i]), m.c);
                end
            end
        end
    end

    task automatic run(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [2:0] ef, input int k);
        int   lat;
        int   bc;
        exp_t e;
        e.id = id;
        e.f  = ef;
        e.c  = k;
        q.push_back(e);
        @(negedge clk);
        av[id] = a;
        bv[id] = b;
        sg[id] = s;
        st[id] = 1'b1;
        @(negedge clk);
        st[id] = 1'b0;
        av[id] = ~a;
        bv[id] = ~b;
        sg[id] = ~s;
        lat = 0;
        bc  = 0;
        while (!done[id] && lat < 40) begin
            if (busy[id]) bc++;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, k);
        chk("busy_cycles", bc, k);
        chk("busy_at_done", int'(busy[id]), 0);
        @(negedge clk);
        chk("done_width", int'(done[id]), 0);
    endtask

    initial begin
        int n;
        int lat;
        int first;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            av[i] = '0;
            bv[i] = '0;
            sg[i] = 1'b0;
        end
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", int'(busy[i]), 0);
            chk("rst_done", int'(done[i]), 0);
            chk("rst_flags", int'({f1s[i], f2s[i], f3s[i]}), 0);
            chk("rst_cycles", int'(cyc[i]), 0);
        end
        rst = 1'b0;

        run(0, 8'h80, 8'h7F, 1'b0, 3'b100, 1);
        run(0, 8'h80, 8'h7F, 1'b1, 3'b001, 1);
        run(0, 8'h5A, 8'h5A, 1'b0, 3'b010, 8);
        run(0, 8'hFF, 8'h80, 1'b1, 3'b100, 2);
        run(0, 8'h01, 8'h00, 1'b0, 3'b100, 8);
        run(1, 8'h03, 8'h02, 1'b0, 3'b100, 4);
        run(1, 8'h40, 8'h80, 1'b0, 3'b001, 1);
        run(2, 8'hF0, 8'h0F, 1'b0, 3'b100, 8);
        run(2, 8'h0F, 8'hF0, 1'b1, 3'b100, 8);
        run(2, 8'h3C, 8'h3C, 1'b1, 3'b010, 8);

        // start held high: next accept one cycle after each done
        e.id = 0;
        e.f  = 3'b001;
        e.c  = 3;
        q.push_back(e);
        q.push_back(e);
        @(negedge clk);
        av[0] = 8'h10;
        bv[0] = 8'h20;
        sg[0] = 1'b0;
        st[0] = 1'b1;
        n     = 0;
        lat   = 0;
        first = 0;
        while (n < 2 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (done[0]) begin
                n++;
                if (n == 1) begin
                    first = lat;
                end else begin
                    st[0] = 1'b0;
                    chk("b2b_gap", lat - first, 4);
                end
            end
        end
        st[0] = 1'b0;
        chk("b2b_count", n, 2);
        @(negedge clk);
        chk("b2b_idle", int'(busy[0]), 0);

        // async reset after edge 3 of an 8-digit compare
        @(negedge clk);
        av[0] = 8'h5A;
        bv[0] = 8'h5A;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", int'(busy[0]), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_flags", int'({f1s[0], f2s[0], f3s[0]}), 0);
        chk("abort_cycles", int'(cyc[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_done_busy", int'(busy[0]), 0);
        run(0, 8'h33, 8'h35, 1'b0, 3'b001, 6);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
